// File: rtl/hack_boot_ctrl.sv
// Boot/run sequencer for the Hack Computer: streams a program into ROM, releases CPU reset, counts run cycles, detects halt loops.
// ROM write latency 1 cycle; in_ready is combinational from state. Optional checksum gate under macro BOOT_CHECKSUM_EN.
module hack_boot_ctrl #(
    parameter int AW           = 15,
    parameter int DW           = 16,
    parameter int RESET_CYCLES = 2,
    parameter int HALT_CYCLES  = 4,
    parameter int CW           = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          abort,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          rom_we,
    output logic [AW-1:0] rom_addr,
    output logic [DW-1:0] rom_wdata,
    output logic          cpu_reset,
    input  logic [AW-1:0] pc,
`ifdef BOOT_CHECKSUM_EN
    input  logic [DW-1:0] exp_sum,
    output logic          sum_err,
`endif
    output logic          busy,
    output logic          halted,
    output logic [CW-1:0] cycles
);

    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int HCW = $clog2(HALT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RHOLD, S_RUN, S_HALT} state_t;

    state_t          state_q, state_d;
    logic [AW:0]     len_q, cnt_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [RCW-1:0]  rst_cnt_q;
    logic [AW-1:0]   pc_d1_q, pc_d2_q;
    logic [1:0]      run_cnt_q;
    logic [HCW-1:0]  halt_cnt_q;
    logic [CW-1:0]   cycles_q;

    logic hs, last_hs, start_acc, halt_cmp, halt_hit, sum_bad;

    assign hs        = in_valid && in_ready;
    assign last_hs   = hs && ((cnt_q + (AW+1)'(1)) == len_q);
    assign start_acc = start && (state_q == S_IDLE || state_q == S_HALT);
    // pc_d2 is only meaningful once two RUN cycles of history exist.
    assign halt_cmp  = (run_cnt_q == 2'd2) && (pc == pc_d2_q);
    assign halt_hit  = halt_cmp && ((halt_cnt_q + HCW'(1)) == HCW'(HALT_CYCLES));

`ifdef BOOT_CHECKSUM_EN
    logic [DW-1:0] sum_q;
    logic          sum_err_q;
    assign sum_bad = last_hs && ((sum_q + in_data) != exp_sum);
    assign sum_err = sum_err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_q     <= '0;
            sum_err_q <= 1'b0;
        end else if (start_acc) begin
            sum_q     <= '0;
            sum_err_q <= 1'b0;
        end else begin
            if (hs)
                sum_q <= sum_q + in_data;
            if (state_q == S_LOAD && !abort && sum_bad)
                sum_err_q <= 1'b1;
        end
    end
`else
    assign sum_bad = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: if (start) state_d = (len == '0) ? S_RHOLD : S_LOAD;
            S_LOAD: begin
                if (abort)        state_d = S_HALT;
                else if (last_hs) state_d = sum_bad ? S_HALT : S_RHOLD;
            end
            S_RHOLD: begin
                if (abort)                                      state_d = S_HALT;
                else if (rst_cnt_q == RCW'(RESET_CYCLES - 1))   state_d = S_RUN;
            end
            S_RUN: if (abort || halt_hit) state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_LOAD) && (cnt_q < len_q);
        busy      = (state_q == S_LOAD) || (state_q == S_RHOLD) || (state_q == S_RUN);
        halted    = (state_q == S_HALT);
        cpu_reset = (state_q != S_RUN);
    end

    assign rom_we    = we_q;
    assign rom_addr  = addr_q;
    assign rom_wdata = wdata_q;
    assign cycles    = cycles_q;

    // A word accepted on the abort cycle is still written one cycle later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_q      <= '0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rst_cnt_q  <= '0;
            pc_d1_q    <= '0;
            pc_d2_q    <= '0;
            run_cnt_q  <= '0;
            halt_cnt_q <= '0;
            cycles_q   <= '0;
        end else begin
            we_q <= hs;
            if (hs) begin
                addr_q  <= cnt_q[AW-1:0];
                wdata_q <= in_data;
                cnt_q   <= cnt_q + (AW+1)'(1);
            end
            if (start_acc) begin
                len_q    <= len;
                cnt_q    <= '0;
                cycles_q <= '0;
            end
            rst_cnt_q <= (state_q == S_RHOLD) ? rst_cnt_q + RCW'(1) : '0;
            if (state_q == S_RUN) begin
                pc_d1_q    <= pc;
                pc_d2_q    <= pc_d1_q;
                if (run_cnt_q != 2'd2)
                    run_cnt_q <= run_cnt_q + 2'd1;
                halt_cnt_q <= halt_cmp ? halt_cnt_q + HCW'(1) : '0;
                if (cycles_q != '1)
                    cycles_q <= cycles_q + CW'(1);
            end else begin
                pc_d1_q    <= '0;
                pc_d2_q    <= '0;
                run_cnt_q  <= '0;
                halt_cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Directed bench for hack_boot_ctrl: expected ROM writes go into a scoreboard queue, a negedge monitor checks every rom_we.
module tb_hack_boot_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] len;
    logic        abort;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_reset;
    logic [14:0] pc;
    logic        busy;
    logic        halted;
    logic [31:0] cycles;
`ifdef BOOT_CHECKSUM_EN
    logic [15:0] exp_sum;
    logic        sum_err;
`endif

    hack_boot_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .len(len), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset), .pc(pc),
`ifdef BOOT_CHECKSUM_EN
        .exp_sum(exp_sum), .sum_err(sum_err),
`endif
        .busy(busy), .halted(halted), .cycles(cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [14:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] prog[$];
    int          errors = 0;
    int          checks = 0;
    int          rdy_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset && in_ready) rdy_cycles++;
        if (reset && rom_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {17'd0, rom_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(rom_addr), 32'(e.a));
                check("wr_data", 32'(rom_wdata), 32'(e.d));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [15:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // Streams prog[0..n-1]; gap inserts one idle cycle between words.
    task automatic load_words(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            in_valid = 1'b1;
            in_data  = prog[i];
            for (int w = 0; w < 20 && !in_ready; w++) tick();
            check("ready_for_word", 32'(in_ready), 32'd1);
            e.a = 15'(i);
            e.d = prog[i];
            exp_q.push_back(e);
            tick();
            in_valid = 1'b0;
            if (gap && i < n - 1) tick();
        end
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    function automatic logic [14:0] halt_pc(input int k);
        if (k <= 9)       return 15'((k - 1) % 4);
        else if (k == 10) return 15'd4;
        else              return 15'd5;
    endfunction

    initial begin
        int k;
        reset = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
        in_data = '0; in_valid = 1'b0; pc = '0;
`ifdef BOOT_CHECKSUM_EN
        exp_sum = '0;
`endif
        #1;
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_halted",    32'(halted),    32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_cycles",    cycles,         32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // 1: back-to-back load of 3 words
        prog = '{16'h0002, 16'hEC10, 16'h0000};
        rdy_cycles = 0;
        do_start(16'd3);
        check("t1_busy", 32'(busy), 32'd1);
        load_words(3, 1'b0);
        check("t1_ready_drop", 32'(in_ready),  32'd0);
        check("t1_rhold0",     32'(cpu_reset), 32'd1);
        tick();
        check("t1_rhold1",     32'(cpu_reset), 32'd1);
        check("t1_load_len",   32'(rdy_cycles), 32'd3);
        tick();
        check("t1_run",        32'(cpu_reset), 32'd0);
        do_abort();
        check("t1_halted",     32'(halted), 32'd1);
        check("t1_cycles",     cycles,      32'd1);
        check("t1_q_empty",    32'(exp_q.size()), 32'd0);

        // 2: toggling valid 1,0,1,0,1
        rdy_cycles = 0;
        do_start(16'd3);
        check("t2_halt_clear", 32'(halted), 32'd0);
        load_words(3, 1'b1);
        tick();
        check("t2_load_len",   32'(rdy_cycles), 32'd5);
        check("t2_q_empty",    32'(exp_q.size()), 32'd0);
        do_abort();

        // 3: 6-word program ending in @5; 0;JMP, PC reaches 4 at run cycle 10
        prog = '{16'h0010, 16'hFC10, 16'h0011, 16'hE308, 16'h0005, 16'hEA87};
        do_start(16'd6);
        load_words(6, 1'b0);
        k = 0;
        for (int t = 0; t < 60 && !halted; t++) begin
            if (!cpu_reset) begin
                k++;
                pc = halt_pc(k);
            end
            tick();
        end
        check("t3_halted",     32'(halted),    32'd1);
        check("t3_run_cycles", 32'(k),         32'd16);
        check("t3_cycles",     cycles,         32'd16);
        check("t3_cpu_reset",  32'(cpu_reset), 32'd1);
        tick(); tick(); tick();
        check("t3_cycles_frozen", cycles, 32'd16);
        check("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // 4: abort after 2 of 5 words, then reload len=1
        prog = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
        do_start(16'd5);
        load_words(2, 1'b0);
        do_abort();
        check("t4_halted",    32'(halted),    32'd1);
        check("t4_in_ready",  32'(in_ready),  32'd0);
        check("t4_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t4_q_empty",   32'(exp_q.size()), 32'd0);
        prog = '{16'h1234};
        do_start(16'd1);
        load_words(1, 1'b0);

        // 5: async reset during RUN at cycles==7
        pc = 15'd100;
        for (int t = 0; t < 40 && cycles != 32'd7; t++) begin
            if (!cpu_reset) pc = pc + 15'd1;
            tick();
        end
        check("t5_reached7",  cycles, 32'd7);
        check("t5_q_empty",   32'(exp_q.size()), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("t5_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t5_busy",      32'(busy),      32'd0);
        check("t5_halted",    32'(halted),    32'd0);
        check("t5_in_ready",  32'(in_ready),  32'd0);
        check("t5_rom_we",    32'(rom_we),    32'd0);
        check("t5_rom_addr",  32'(rom_addr),  32'd0);
        check("t5_rom_wdata", 32'(rom_wdata), 32'd0);
        check("t5_cycles",    cycles,         32'd0);
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        check("t5_idle_busy", 32'(busy), 32'd0);

        // start with abort in IDLE, len=0 runs existing ROM
        start = 1'b1; abort = 1'b1; len = 16'd0;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_busy",      32'(busy),      32'd1);
        check("sa_halted",    32'(halted),    32'd0);
        check("sa_in_ready",  32'(in_ready),  32'd0);
        tick();
        check("sa_rhold",     32'(cpu_reset), 32'd1);
        tick();
        check("sa_run",       32'(cpu_reset), 32'd0);
        do_abort();
        check("sa_halted2",   32'(halted), 32'd1);

`ifdef BOOT_CHECKSUM_EN
        // 6: checksum mismatch then match
        prog = '{16'h0001, 16'h0002};
        exp_sum = 16'h0004;
        do_start(16'd2);
        load_words(2, 1'b0);
        check("t6_sum_err",   32'(sum_err),   32'd1);
        check("t6_halted",    32'(halted),    32'd1);
        check("t6_cpu_reset", 32'(cpu_reset), 32'd1);
        exp_sum = 16'h0003;
        do_start(16'd2);
        check("t6_err_clear", 32'(sum_err), 32'd0);
        load_words(2, 1'b0);
        check("t6_ok_halted", 32'(halted), 32'd0);
        tick(); tick();
        check("t6_run",       32'(cpu_reset), 32'd0);
        check("t6_sum_ok",    32'(sum_err),   32'd0);
        do_abort();
`endif

        tick();
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hack_boot_ctrl.md
Name: hack_boot_ctrl

Overview:
Boot and run sequencer for the Hack Computer.
- Accepts a program as a stream of 16-bit words over a valid/ready handshake and writes it into instruction ROM.
- Holds the CPU in reset during loading, releases it, and counts run cycles.
- Flags halt when the PC settles into a terminal loop of period 1 or 2, such as `@END; 0;JMP`.
- Sits between the testbench or host side and the Computer's ROM write port and CPU reset.

Parameters:
- AW, 15, ROM address width.
- DW, 16, instruction word width.
- RESET_CYCLES, 2, cycles cpu_reset is held high after load and before run; minimum 1.
- HALT_CYCLES, 4, consecutive cycles that pc==pc delayed by 2 must hold to declare halt; minimum 1.
- CW, 32, cycle counter width.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low (0 = reset).
- start  input  1  begin load sequence; sampled in IDLE and HALT only.
- len  input  AW+1  number of words to load, 0..2^AW; sampled with start.
- abort  input  1  force HALT from LOAD, RESET_HOLD or RUN.
- in_data  input  DW  program word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  controller accepts a word this cycle.
- rom_we  output  1  ROM write strobe.
- rom_addr  output  AW  ROM write address.
- rom_wdata  output  DW  ROM write data.
- cpu_reset  output  1  active-high reset to the Computer.
- pc  input  AW  CPU program counter.
- busy  output  1  high in LOAD, RESET_HOLD and RUN.
- halted  output  1  high in HALT.
- cycles  output  CW  clocks spent in RUN.

Behaviour:
- Async reset (reset==0):
  - State goes to IDLE.
  - Outputs: cpu_reset=1, in_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, busy=0, halted=0, cycles=0.
  - Internal word counter, pc history and halt counter are cleared.
- States: IDLE, LOAD, RESET_HOLD, RUN, HALT. cpu_reset=1 in every state except RUN.
- IDLE, on start:
  - len!=0: latch len, clear word counter and cycles, go to LOAD.
  - len==0: go to RESET_HOLD and run the existing ROM contents.
- LOAD:
  - in_ready=1 combinationally while in LOAD and count<len.
  - On handshake (in_valid && in_ready), the next cycle has rom_we=1, rom_addr=count, rom_wdata=in_data. So write latency is 1 cycle and rom_we is registered.
  - count increments on each handshake.
  - Back-to-back handshakes are allowed: one word per cycle.
  - After the handshake that makes count==len, in_ready drops the next cycle. State moves to RESET_HOLD in the same cycle as the final rom_we.
  - in_valid with in_ready=0 is ignored; the word is not consumed.
  - rom_addr wraps at 2^AW; this is only reachable when len==2^AW, which writes every address exactly once.
- RESET_HOLD:
  - Hold cpu_reset=1 for exactly RESET_CYCLES clocks, then go to RUN.
  - Clear the pc history and halt counter on exit.
- RUN:
  - cpu_reset=0; cycles increments every clock and saturates at all-ones.
  - Halt detection:
    - Register pc_d1 and pc_d2.
    - From the third RUN cycle onward, if pc==pc_d2 the halt counter increments; otherwise it clears.
    - When the counter reaches HALT_CYCLES, go to HALT.
  - A self-loop (period 1) also satisfies pc==pc_d2.
- HALT:
  - halted=1 and cpu_reset=1; cycles is frozen.
  - start behaves exactly as in IDLE, and halted clears on exit.
- abort:
  - Goes to HALT next cycle from LOAD, RESET_HOLD or RUN.
  - Takes priority over every other transition.
  - A write already registered still completes (rom_we may be 1 on the abort+1 cycle).
- start while busy is ignored.
- start and abort asserted together in IDLE: start wins, since abort has no effect in IDLE.
- Reset asserted mid-operation: immediate return to the reset values above. The CPU is held in reset and any pending write strobe is dropped.

Optional Feature:
- Macro BOOT_CHECKSUM_EN.
- When defined:
  - Adds input exp_sum[DW-1:0] and output sum_err.
  - Keeps a mod-2^DW additive sum of every accepted word, cleared on start.
  - On leaving LOAD normally, if sum != exp_sum, go to HALT with sum_err=1 instead of RESET_HOLD. The CPU is never released.
  - sum_err clears on start and on reset.
  - With len==0 the check is skipped.
- When undefined: no extra ports, and LOAD always proceeds to RESET_HOLD.

Test Plan:
1. reset low, then high; start with len=3; stream 0x0002, 0xEC10, 0x0000 with in_valid held high.
   -> rom_we pulses on 3 consecutive cycles, addr 0,1,2 with matching data.
   -> in_ready=0 after the third word; cpu_reset high for 2 cycles, then low.
2. Same load with in_valid toggling 1,0,1,0,1.
   -> Exactly 3 writes, no duplicate or skipped address; LOAD lasts 5 cycles.
3. Load `@5; 0;JMP` at addr 4..5 of a 6-word program whose PC reaches addr 4 at RUN cycle 10.
   -> halted=1 after the HALT_CYCLES=4 qualifying cycles.
   -> cycles freezes; cpu_reset=1.
4. abort asserted mid-LOAD after 2 of 5 words.
   -> HALT next cycle, halted=1; in_ready=0; cpu_reset never deasserted.
   -> A new start with len=1 reloads from addr 0.
5. Assert reset low during RUN at cycles=7.
   -> All outputs return to their reset values asynchronously.
   -> Releasing reset returns to IDLE, with no ROM write issued.
6. (BOOT_CHECKSUM_EN) Load 0x0001, 0x0002 with exp_sum=0x0004.
   -> sum_err=1, HALT; cpu_reset stays 1.
   -> Rerun with exp_sum=0x0003 -> RUN reached, sum_err=0.
